// File: rtl/pipe_scheduler.sv
// Game sequencer: scrolls and respawns three pipes, keeps a BCD score, detects crashes.
// Latency: frame_tick -> pipe update 1 clk, crash -> fail 1 clk; no backpressure, every input is taken each cycle.
module pipe_scheduler #(
  parameter int          SCROLL_STEP   = 2,
  parameter int          PIPE_SPACING  = 200,
  parameter int          PIPE_GAP      = 120,
  parameter int          H_MIN         = 60,
  parameter int          PIPE_W        = 50,
  parameter int          MARIO_X       = 40,
  parameter int          MARIO_W       = 16,
  parameter int          MARIO_H       = 16,
  parameter int          FLOOR_Y       = 464,
  parameter int          PIPE_HEAD_ADJ = 21,
  parameter logic [15:0] LFSR_SEED     = 16'hACE1
) (
  input  logic        clk,
  input  logic        clrn,
  input  logic        start,
  input  logic        frame_tick,
  input  logic [9:0]  mario_y,
  output logic [31:0] pipe_1,
  output logic [31:0] pipe_2,
  output logic [31:0] pipe_3,
  output logic [15:0] score,
  output logic        fail
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DEAD} state_t;

  localparam logic [9:0]  STEP     = 10'(SCROLL_STEP);
  localparam logic [9:0]  RESPAWN  = 10'(3 * PIPE_SPACING);
  localparam logic [9:0]  HMIN     = 10'(H_MIN);
  localparam logic [9:0]  MX       = 10'(MARIO_X);
  localparam logic [7:0]  GAP      = 8'(PIPE_GAP);
  localparam logic [10:0] OV_LO    = 11'(MARIO_X);
  localparam logic [10:0] OV_HI    = 11'(MARIO_X + MARIO_W);
  localparam logic [10:0] PW       = 11'(PIPE_W);
  localparam logic [10:0] MH       = 11'(MARIO_H);
  localparam logic [10:0] BOT_ADJ  = 11'(PIPE_GAP + PIPE_HEAD_ADJ);
  localparam logic [10:0] FLOOR    = 11'(FLOOR_Y);
  localparam logic [2:0][9:0] X_RST = {10'd800, 10'd600, 10'd400};
  localparam logic [2:0][9:0] H_RST = {10'd120, 10'd200, 10'd160};

  state_t          state_q, state_d;
  logic [2:0][9:0] x_q, x_d, h_q, h_d;
  logic [15:0]     score_q, score_d;
  logic            fail_q, fail_d;
  logic [15:0]     lfsr_q, lfsr_d;

  logic [2:0]      hit;
  logic            crash;
  logic [2:0][9:0] x_scr, h_scr;
  logic [15:0]     score_scr;

  function automatic logic [15:0] bcd_inc(input logic [15:0] s);
    logic [15:0] r;
    logic        carry;
    r     = s;
    carry = 1'b1;
    if (s != 16'h9999) begin
      for (int d = 0; d < 4; d++) begin
        if (carry) begin
          if (r[d*4 +: 4] == 4'd9) begin
            r[d*4 +: 4] = 4'd0;
          end else begin
            r[d*4 +: 4] = r[d*4 +: 4] + 4'd1;
            carry       = 1'b0;
          end
        end
      end
    end
    return r;
  endfunction

  // Galois form of x^16+x^14+x^13+x^11+1; a nonzero seed never reaches zero.
  always_comb begin
    lfsr_d = {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
  end

  // 11-bit compares so pipe and mario extents never wrap.
  always_comb begin
    hit = '0;
    for (int i = 0; i < 3; i++) begin
      hit[i] = ({1'b0, x_q[i]} < OV_HI) && (({1'b0, x_q[i]} + PW) > OV_LO) &&
               (({1'b0, mario_y} < {1'b0, h_q[i]}) ||
                (({1'b0, mario_y} + MH) > ({1'b0, h_q[i]} + BOT_ADJ)));
    end
    crash = (|hit) || ({1'b0, mario_y} >= FLOOR);
  end

  always_comb begin
    x_scr     = x_q;
    h_scr     = h_q;
    score_scr = score_q;
    for (int i = 0; i < 3; i++) begin
      if (x_q[i] >= STEP) begin
        x_scr[i] = x_q[i] - STEP;
      end else begin
        x_scr[i] = x_q[i] - STEP + RESPAWN;
        h_scr[i] = HMIN + {2'b00, lfsr_q[7:0]};
      end
      if ((x_q[i] >= MX) && (x_scr[i] < MX)) begin
        score_scr = bcd_inc(score_scr);
      end
    end
  end

  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    h_d     = h_q;
    score_d = score_q;
    fail_d  = fail_q;
    case (state_q)
      S_IDLE: begin
        if (start) state_d = S_RUN;
      end
      S_RUN: begin
        // A crash still lets this tick's scroll and score land before freezing.
        if (frame_tick) begin
          x_d     = x_scr;
          h_d     = h_scr;
          score_d = score_scr;
        end
        if (crash) begin
          state_d = S_DEAD;
          fail_d  = 1'b1;
        end
      end
      S_DEAD: begin
        if (start) begin
          state_d = S_RUN;
          x_d     = X_RST;
          h_d     = H_RST;
          score_d = 16'h0000;
          fail_d  = 1'b0;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge clrn) begin
    if (!clrn) begin
      state_q <= S_IDLE;
      x_q     <= X_RST;
      h_q     <= H_RST;
      score_q <= 16'h0000;
      fail_q  <= 1'b0;
      lfsr_q  <= LFSR_SEED;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      h_q     <= h_d;
      score_q <= score_d;
      fail_q  <= fail_d;
      lfsr_q  <= lfsr_d;
    end
  end

  assign pipe_1 = {4'b0000, GAP, x_q[0], h_q[0]};
  assign pipe_2 = {4'b0000, GAP, x_q[1], h_q[1]};
  assign pipe_3 = {4'b0000, GAP, x_q[2], h_q[2]};
  assign score  = score_q;
  assign fail   = fail_q;

endmodule

// File: tb/tb_pipe_scheduler.sv
// Bench for pipe_scheduler: fixed vector table, directed corner sequences, randomized run against a game model.
module tb_pipe_scheduler;

  logic        clk;
  logic        clrn;
  logic        start;
  logic        frame_tick;
  logic [9:0]  mario_y;
  logic [31:0] pipe_1, pipe_2, pipe_3;
  logic [15:0] score;
  logic        fail;

  int checks   = 0;
  int failures = 0;

  pipe_scheduler dut (
    .clk        (clk),
    .clrn       (clrn),
    .start      (start),
    .frame_tick (frame_tick),
    .mario_y    (mario_y),
    .pipe_1     (pipe_1),
    .pipe_2     (pipe_2),
    .pipe_3     (pipe_3),
    .score      (score),
    .fail       (fail)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog act=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  // Game model: 0 idle, 1 run, 2 dead; score kept as a plain integer.
  int          m_state;
  int          m_x [3];
  int          m_h [3];
  int          m_score;
  logic [15:0] m_lfsr;

  localparam logic [31:0] P1_RST = {4'b0, 8'd120, 10'd400, 10'd160};
  localparam logic [31:0] P2_RST = {4'b0, 8'd120, 10'd600, 10'd200};
  localparam logic [31:0] P3_RST = {4'b0, 8'd120, 10'd800, 10'd120};

  task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%h exp=%h", nm, act, exp);
    end
  endtask

  function automatic logic [15:0] to_bcd(input int n);
    logic [15:0] r;
    r[15:12] = 4'((n / 1000) % 10);
    r[11:8]  = 4'((n / 100) % 10);
    r[7:4]   = 4'((n / 10) % 10);
    r[3:0]   = 4'(n % 10);
    return r;
  endfunction

  function automatic logic [31:0] pipe_word(input int x, input int h);
    return {4'b0, 8'd120, 10'(x), 10'(h)};
  endfunction

  task automatic model_reset();
    m_state = 0;
    m_x[0] = 400; m_x[1] = 600; m_x[2] = 800;
    m_h[0] = 160; m_h[1] = 200; m_h[2] = 120;
    m_score = 0;
    m_lfsr  = 16'hACE1;
  endtask

  task automatic model_step(input bit st, input bit tk, input int my);
    logic [15:0] l;
    bit          hit;
    int          nx;
    l   = m_lfsr;
    hit = 0;
    for (int i = 0; i < 3; i++) begin
      if (m_x[i] < 40 + 16 && m_x[i] + 50 > 40 &&
          (my < m_h[i] || my + 16 > m_h[i] + 120 + 21)) hit = 1;
    end
    if (my >= 464) hit = 1;
    case (m_state)
      0: if (st) m_state = 1;
      1: begin
        if (tk) begin
          for (int i = 0; i < 3; i++) begin
            if (m_x[i] >= 2) nx = m_x[i] - 2;
            else begin
              nx = (m_x[i] - 2 + 600) % 1024;
              m_h[i] = 60 + int'(l[7:0]);
            end
            if (m_x[i] >= 40 && nx < 40 && m_score < 9999) m_score++;
            m_x[i] = nx;
          end
        end
        if (hit) m_state = 2;
      end
      default: if (st) begin
        m_x[0] = 400; m_x[1] = 600; m_x[2] = 800;
        m_h[0] = 160; m_h[1] = 200; m_h[2] = 120;
        m_score = 0;
        m_state = 1;
      end
    endcase
    if (l[0]) m_lfsr = (l >> 1) ^ 16'hB400;
    else      m_lfsr = l >> 1;
  endtask

  task automatic check_all();
    check("pipe_1", pipe_1, pipe_word(m_x[0], m_h[0]));
    check("pipe_2", pipe_2, pipe_word(m_x[1], m_h[1]));
    check("pipe_3", pipe_3, pipe_word(m_x[2], m_h[2]));
    check("score", score, to_bcd(m_score));
    check("fail", fail, (m_state == 2) ? 32'd1 : 32'd0);
  endtask

  // Called at a negedge: drive, advance model across the next posedge, compare at the following negedge.
  task automatic cycle(input bit st, input bit tk, input int my);
    start      = st;
    frame_tick = tk;
    mario_y    = 10'(my);
    model_step(st, tk, my);
    @(negedge clk);
    check_all();
  endtask

  function automatic int safe_y();
    int y;
    y = 200;
    for (int i = 0; i < 3; i++) if (m_x[i] < 56) y = m_h[i] + 20;
    return y;
  endfunction

  task automatic pulse_reset(input string nm);
    #2 clrn = 1'b0;
    #1;
    model_reset();
    check({nm, "_p1"}, pipe_1, P1_RST);
    check({nm, "_p2"}, pipe_2, P2_RST);
    check({nm, "_p3"}, pipe_3, P3_RST);
    check({nm, "_score"}, score, 32'd0);
    check({nm, "_fail"}, fail, 32'd0);
    @(negedge clk);
    clrn = 1'b1;
  endtask

  typedef struct {
    bit          st;
    bit          tk;
    int          my;
    bit          e_fail;
    int          e_x1;
    int          e_x2;
    int          e_x3;
    logic [15:0] e_score;
  } vec_t;

  vec_t tbl [13];

  initial begin
    bit          seen;
    logic [15:0] l;
    bit          st, tk;
    int          my;

    tbl[0]  = '{1'b0, 1'b1, 200, 1'b0, 400, 600, 800, 16'h0000};
    tbl[1]  = '{1'b0, 1'b1, 464, 1'b0, 400, 600, 800, 16'h0000};
    tbl[2]  = '{1'b1, 1'b1, 200, 1'b0, 400, 600, 800, 16'h0000};
    tbl[3]  = '{1'b0, 1'b1, 200, 1'b0, 398, 598, 798, 16'h0000};
    tbl[4]  = '{1'b0, 1'b0, 200, 1'b0, 398, 598, 798, 16'h0000};
    tbl[5]  = '{1'b1, 1'b1, 200, 1'b0, 396, 596, 796, 16'h0000};
    tbl[6]  = '{1'b0, 1'b1, 464, 1'b1, 394, 594, 794, 16'h0000};
    tbl[7]  = '{1'b0, 1'b1, 200, 1'b1, 394, 594, 794, 16'h0000};
    tbl[8]  = '{1'b0, 1'b1, 200, 1'b1, 394, 594, 794, 16'h0000};
    tbl[9]  = '{1'b1, 1'b0, 200, 1'b0, 400, 600, 800, 16'h0000};
    tbl[10] = '{1'b0, 1'b1, 463, 1'b0, 398, 598, 798, 16'h0000};
    tbl[11] = '{1'b0, 1'b0, 464, 1'b1, 398, 598, 798, 16'h0000};
    tbl[12] = '{1'b1, 1'b1, 200, 1'b0, 400, 600, 800, 16'h0000};

    clrn = 1'b0; start = 1'b0; frame_tick = 1'b0; mario_y = 10'd200;
    model_reset();
    @(negedge clk);
    check("rst_p1", pipe_1, P1_RST);
    check("rst_p2", pipe_2, P2_RST);
    check("rst_p3", pipe_3, P3_RST);
    check("rst_score", score, 32'd0);
    check("rst_fail", fail, 32'd0);
    clrn = 1'b1;

    // Idle: ticks without start leave everything at reset values.
    for (int n = 0; n < 10; n++) cycle(1'b0, 1'b1, 200);
    check("idle_hold_p1", pipe_1, P1_RST);
    check("idle_hold_p3", pipe_3, P3_RST);

    for (int i = 0; i < 13; i++) begin
      start = tbl[i].st; frame_tick = tbl[i].tk; mario_y = 10'(tbl[i].my);
      model_step(tbl[i].st, tbl[i].tk, tbl[i].my);
      @(negedge clk);
      check($sformatf("tbl%0d_p1", i), pipe_1, pipe_word(tbl[i].e_x1, 160));
      check($sformatf("tbl%0d_x2", i), pipe_2[19:10], tbl[i].e_x2);
      check($sformatf("tbl%0d_x3", i), pipe_3[19:10], tbl[i].e_x3);
      check($sformatf("tbl%0d_fail", i), fail, tbl[i].e_fail);
      check($sformatf("tbl%0d_score", i), score, tbl[i].e_score);
    end

    // Scroll 100 ticks, then pass mario, then respawn from x=0.
    pulse_reset("rst2");
    cycle(1'b1, 1'b0, 200);
    for (int n = 0; n < 100; n++) cycle(1'b0, 1'b1, 200);
    check("scroll_x1", pipe_1[19:10], 32'd200);
    check("scroll_x3", pipe_3[19:10], 32'd600);
    seen = 0;
    for (int n = 0; n < 400 && m_x[0] != 0; n++) begin
      cycle(1'b0, 1'b1, safe_y());
      if (m_x[0] == 38 && !seen) begin
        seen = 1;
        check("score_first", score, 32'h0001);
      end
    end
    check("reach_x0", pipe_1[19:10], 32'd0);
    l = m_lfsr;
    cycle(1'b0, 1'b1, safe_y());
    check("respawn_x", pipe_1[19:10], 32'd598);
    check("respawn_h", pipe_1[9:0], 32'd60 + 32'(l[7:0]));

    // BCD carries across one and two digits.
    seen = 0;
    for (int n = 0; n < 20000 && m_score < 100; n++) begin
      cycle(1'b0, 1'b1, safe_y());
      if (m_score == 10 && !seen) begin
        seen = 1;
        check("score_0010", score, 32'h0010);
      end
    end
    check("score_0100", score, 32'h0100);

    // Pipe crash at x=30, freeze while dead, restart.
    pulse_reset("rst3");
    cycle(1'b1, 1'b0, 200);
    for (int n = 0; n < 300 && m_x[0] != 30; n++) cycle(1'b0, 1'b1, safe_y());
    check("crash_x30", pipe_1, pipe_word(30, 160));
    check("crash_prefail", fail, 32'd0);
    cycle(1'b0, 1'b0, 100);
    check("crash_fail", fail, 32'd1);
    for (int n = 0; n < 5; n++) cycle(1'b0, 1'b1, 100);
    check("dead_frozen", pipe_1, pipe_word(30, 160));
    cycle(1'b1, 1'b0, 100);
    check("restart_p1", pipe_1, P1_RST);
    check("restart_p2", pipe_2, P2_RST);
    check("restart_fail", fail, 32'd0);
    check("restart_score", score, 32'd0);

    // Floor crash, then asynchronous reset in the middle of a run.
    cycle(1'b0, 1'b1, 464);
    check("floor_fail", fail, 32'd1);
    cycle(1'b1, 1'b0, 200);
    for (int n = 0; n < 3; n++) cycle(1'b0, 1'b1, 200);
    pulse_reset("midrun");
    cycle(1'b0, 1'b1, 200);
    check("post_rst_idle", pipe_1, P1_RST);

    // Randomized game play against the model.
    for (int n = 0; n < 3000; n++) begin
      st = ($urandom_range(0, 19) == 0);
      tk = ($urandom_range(0, 3) != 0);
      my = ($urandom_range(0, 199) == 0) ? int'($urandom_range(0, 1023)) : safe_y();
      cycle(st, tk, my);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
